// File: rtl/scmp_microcode_seq_if.sv
// scmp_seq_if
// Bundles the signals between the microcode ROM / opcode decoder side and
// the SC/MP microprogram sequencer.
//   master : ROM/decoder side, drives the sequencing controls and samples
//            upc / dly_busy / halt_o
//   slave  : sequencer side
// Signals: clken, mem_wait, nxt_sel[1:0], jmp_addr, cond, op_pc, op_dly,
//          ac_i[7:0], disp_i[7:0], ucode_halt, cont_i  (to sequencer)
//          upc, dly_busy, halt_o                      (from sequencer)
interface scmp_seq_if #(
    parameter int UPC_W = 8
);
    logic             clken;
    logic             mem_wait;
    logic [1:0]       nxt_sel;
    logic [UPC_W-1:0] jmp_addr;
    logic             cond;
    logic [UPC_W-1:0] op_pc;
    logic             op_dly;
    logic [7:0]       ac_i;
    logic [7:0]       disp_i;
    logic             ucode_halt;
    logic             cont_i;
    logic [UPC_W-1:0] upc;
    logic             dly_busy;
    logic             halt_o;

    modport master (
        output clken, mem_wait, nxt_sel, jmp_addr, cond, op_pc, op_dly,
               ac_i, disp_i, ucode_halt, cont_i,
        input  upc, dly_busy, halt_o
    );

    modport slave (
        input  clken, mem_wait, nxt_sel, jmp_addr, cond, op_pc, op_dly,
               ac_i, disp_i, ucode_halt, cont_i,
        output upc, dly_busy, halt_o
    );
endinterface

// File: rtl/scmp_microcode_seq.sv
// scmp_microcode_seq
// Microprogram sequencer for the SC/MP core: holds the micro-PC, selects the
// next micro-address from the ROM next-address field, stalls on memory waits,
// runs the DLY instruction delay counter and parks on HALT.
// Ports:
//   clk  : core clock
//   rst  : asynchronous, active-high reset
//   bus  : scmp_seq_if.slave (controls in, upc / dly_busy / halt_o out)
// Build option: define SCMP_DLY_EN to build the DLY state and delay counter.
// Without it, op_dly is ignored and dly_busy is tied low.
//
// state  | meaning
// S_RUN  | normal microcode sequencing
// S_DLY  | DLY instruction counting, upc frozen
// S_HALT | parked until a continue pulse
module scmp_microcode_seq #(
    parameter int               UPC_W      = 8,
    parameter logic [UPC_W-1:0] RESET_ADDR = '0,
    parameter int               DLY_W      = 18
) (
    input logic       clk,
    input logic       rst,
    scmp_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DLY  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [UPC_W-1:0] r_upc;
    logic [UPC_W-1:0] w_upc_nxt;
    logic [UPC_W-1:0] w_upc_inc;
    logic             r_halt;

    assign w_upc_inc = r_upc + UPC_W'(1);

`ifdef SCMP_DLY_EN
    logic [DLY_W-1:0] r_dly_cnt;
    logic [DLY_W-1:0] w_dly_cnt_nxt;
    logic [DLY_W-1:0] w_dly_load;
    logic             r_dly_busy;

    // 13 + 2*AC + 514*disp; the worst case (131593) fits the 18-bit default.
    assign w_dly_load = DLY_W'(13)
                      + (DLY_W'(bus.ac_i) << 1)
                      + DLY_W'(bus.disp_i) * DLY_W'(514);
`else
    localparam int p_unused_dly_w = DLY_W;
    logic w_unused_dly;
    assign w_unused_dly = ^{bus.op_dly, bus.ac_i, bus.disp_i};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_upc_nxt   = r_upc;
`ifdef SCMP_DLY_EN
        w_dly_cnt_nxt = r_dly_cnt;
`endif
        case (r_state)
            S_RUN: begin
                if (!bus.mem_wait) begin
                    if (bus.ucode_halt) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        case (bus.nxt_sel)
                            2'b00: w_upc_nxt = w_upc_inc;
                            2'b01: w_upc_nxt = bus.jmp_addr;
                            2'b10: begin
                                w_upc_nxt = bus.op_pc;
`ifdef SCMP_DLY_EN
                                if (bus.op_dly) begin
                                    w_state_nxt   = S_DLY;
                                    w_dly_cnt_nxt = w_dly_load;
                                end
`endif
                            end
                            2'b11: w_upc_nxt = bus.cond ? bus.jmp_addr : w_upc_inc;
                        endcase
                    end
                end
            end
            S_DLY: begin
`ifdef SCMP_DLY_EN
                // <=1 also covers a zero count, so DLY can never lock up.
                if (r_dly_cnt <= DLY_W'(1)) begin
                    w_dly_cnt_nxt = '0;
                    w_state_nxt   = S_RUN;
                end else begin
                    w_dly_cnt_nxt = r_dly_cnt - DLY_W'(1);
                end
`else
                w_state_nxt = S_RUN;
`endif
            end
            S_HALT: begin
                if (bus.cont_i && !bus.mem_wait) begin
                    w_state_nxt = S_RUN;
                    w_upc_nxt   = w_upc_inc;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Status flags are registered from the next state so they line up with
    // r_state without any input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_upc   <= RESET_ADDR;
            r_halt  <= 1'b0;
`ifdef SCMP_DLY_EN
            r_dly_cnt  <= '0;
            r_dly_busy <= 1'b0;
`endif
        end else if (bus.clken) begin
            r_state <= w_state_nxt;
            r_upc   <= w_upc_nxt;
            r_halt  <= (w_state_nxt == S_HALT);
`ifdef SCMP_DLY_EN
            r_dly_cnt  <= w_dly_cnt_nxt;
            r_dly_busy <= (w_state_nxt == S_DLY);
`endif
        end
    end

    assign bus.upc    = r_upc;
    assign bus.halt_o = r_halt;
`ifdef SCMP_DLY_EN
    assign bus.dly_busy = r_dly_busy;
`else
    assign bus.dly_busy = 1'b0;
`endif

endmodule
